// File: rtl/coffee_dispense_sched_if.sv
// Order/cup handshake and status bundle between the coffee machine controller and its host.
// Inputs are level/pulse signals sampled on the rising clock edge; there is no valid/ready back-pressure.
interface coffee_dispense_sched_if;
    logic       order;
    logic       cup_ready;
    logic       cup_drop;
    logic       valve_open;
    logic       busy;
    logic [1:0] pending;
    logic [7:0] served_cnt;
    logic       overflow;
    logic       fault;

    modport slave (
        input  order, cup_ready,
        output cup_drop, valve_open, busy, pending, served_cnt, overflow, fault
    );

    modport master (
        output order, cup_ready,
        input  cup_drop, valve_open, busy, pending, served_cnt, overflow, fault
    );
endinterface

// File: rtl/coffee_dispense_sched.sv
// Coffee dispense scheduler: queues orders, drops a cup, pours while the cup is present, then rinses.
// One shared down-timer paces WAIT_CUP, POUR and RINSE; the FSM state is exposed on state_o.
module coffee_dispense_sched #(
    parameter int unsigned POUR_CYCLES  = 8,
    parameter int unsigned RINSE_CYCLES = 2,
    parameter int unsigned CUP_TIMEOUT  = 16,
    parameter int unsigned QUEUE_DEPTH  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    coffee_dispense_sched_if.slave  bus,
    output logic [2:0]              state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DROP     = 3'd1,
        S_WAIT_CUP = 3'd2,
        S_POUR     = 3'd3,
        S_RINSE    = 3'd4
    } state_e;

    // Timer holds "cycles left minus one", so it is loaded with N-1 on entry.
    localparam logic [7:0] POUR_LOAD  = 8'(POUR_CYCLES - 1);
    localparam logic [7:0] RINSE_LOAD = 8'(RINSE_CYCLES - 1);
    localparam logic [7:0] CUP_LOAD   = 8'(CUP_TIMEOUT - 1);
    localparam logic [1:0] DEPTH      = 2'(QUEUE_DEPTH);

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] pending_q, pending_d;
    logic [7:0] served_q, served_d;
    logic       overflow_q, overflow_d;
    logic       fault_q, fault_d;
    logic       dequeue;
    logic       accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            timer_q    <= 8'd0;
            pending_q  <= 2'd0;
            served_q   <= 8'd0;
            overflow_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            served_q   <= served_d;
            overflow_q <= overflow_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        served_d = served_q;
        fault_d  = 1'b0;
        dequeue  = (state_q == S_IDLE) && (pending_q != 2'd0);

        case (state_q)
            S_IDLE: begin
                if (dequeue) state_d = S_DROP;
            end
            S_DROP: begin
                state_d = S_WAIT_CUP;
                timer_d = CUP_LOAD;
            end
            S_WAIT_CUP: begin
                if (bus.cup_ready) begin
                    state_d = S_POUR;
                    timer_d = POUR_LOAD;
                end else if (timer_q == 8'd0) begin
                    state_d = S_DROP;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            S_POUR: begin
                // A missing cup aborts even on the final pour cycle.
                if (!bus.cup_ready) begin
                    state_d = S_RINSE;
                    timer_d = RINSE_LOAD;
                    fault_d = 1'b1;
                end else if (timer_q == 8'd0) begin
                    state_d  = S_RINSE;
                    timer_d  = RINSE_LOAD;
                    served_d = served_q + 8'd1;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            S_RINSE: begin
                if (timer_q == 8'd0) state_d = S_IDLE;
                else                 timer_d = timer_q - 8'd1;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = 8'd0;
            end
        endcase
    end

    // A full queue still takes an order when a slot is freed on the same edge.
    always_comb begin
        accept     = bus.order && ((pending_q != DEPTH) || dequeue);
        overflow_d = bus.order && (pending_q == DEPTH) && !dequeue;
        pending_d  = pending_q;
        case ({accept, dequeue})
            2'b10:   pending_d = pending_q + 2'd1;
            2'b01:   pending_d = pending_q - 2'd1;
            default: pending_d = pending_q;
        endcase
    end

    assign bus.cup_drop   = (state_q == S_DROP);
    assign bus.valve_open = (state_q == S_POUR);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.pending    = pending_q;
    assign bus.served_cnt = served_q;
    assign bus.overflow   = overflow_q;
    assign bus.fault      = fault_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_coffee_dispense_sched.sv
// Bench for coffee_dispense_sched: directed scenarios plus random orders/cup dropouts
// compared cycle by cycle against a phase/elapsed-count model of the machine.
module tb_coffee_dispense_sched;

    localparam int POUR_CYCLES  = 8;
    localparam int RINSE_CYCLES = 2;
    localparam int CUP_TIMEOUT  = 16;
    localparam int QUEUE_DEPTH  = 3;

    localparam int PH_IDLE  = 0;
    localparam int PH_DROP  = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_POUR  = 3;
    localparam int PH_RINSE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    coffee_dispense_sched_if bus ();

    coffee_dispense_sched #(
        .POUR_CYCLES (POUR_CYCLES),
        .RINSE_CYCLES(RINSE_CYCLES),
        .CUP_TIMEOUT (CUP_TIMEOUT),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .state_o(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int m_phase, m_elapsed, m_pend, m_served;
    bit m_ovf, m_fault;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    task automatic model_reset();
        m_phase = PH_IDLE; m_elapsed = 0; m_pend = 0; m_served = 0;
        m_ovf = 0; m_fault = 0;
    endtask

    task automatic model_goto(input int ph);
        m_phase = ph;
        m_elapsed = 0;
    endtask

    task automatic model_step(input bit o, input bit c);
        bit deq;
        deq = (m_phase == PH_IDLE) && (m_pend > 0);
        m_ovf = 0;
        m_fault = 0;
        if (o) begin
            if (m_pend < QUEUE_DEPTH || deq) m_pend++;
            else m_ovf = 1;
        end
        if (deq) m_pend--;
        case (m_phase)
            PH_IDLE: if (deq) model_goto(PH_DROP);
            PH_DROP: model_goto(PH_WAIT);
            PH_WAIT: begin
                if (c) model_goto(PH_POUR);
                else begin
                    m_elapsed++;
                    if (m_elapsed == CUP_TIMEOUT) model_goto(PH_DROP);
                end
            end
            PH_POUR: begin
                if (!c) begin
                    m_fault = 1;
                    model_goto(PH_RINSE);
                end else begin
                    m_elapsed++;
                    if (m_elapsed == POUR_CYCLES) begin
                        m_served = (m_served + 1) % 256;
                        model_goto(PH_RINSE);
                    end
                end
            end
            default: begin
                m_elapsed++;
                if (m_elapsed == RINSE_CYCLES) model_goto(PH_IDLE);
            end
        endcase
    endtask

    function automatic logic [15:0] model_vec();
        logic [15:0] v;
        v = {1'b0, m_phase == PH_DROP, m_phase == PH_POUR, m_phase != PH_IDLE,
             2'(m_pend), 8'(m_served), m_ovf, m_fault};
        return v;
    endfunction

    function automatic logic [15:0] dut_vec();
        return {1'b0, bus.cup_drop, bus.valve_open, bus.busy, bus.pending,
                bus.served_cnt, bus.overflow, bus.fault};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input bit o, input bit c);
        logic [15:0] e;
        bus.order = o;
        bus.cup_ready = c;
        @(posedge clk);
        model_step(o, c);
        exp_q.push_back(model_vec());
        @(negedge clk);
        e = exp_q.pop_front();
        check("outputs", dut_vec(), e);
    endtask

    // Called just after a falling edge; reset lands mid-cycle with no clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", dut_vec(), 16'h0);
        model_reset();
        exp_q.delete();
        bus.order = 1'b0;
        bus.cup_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int exp_pend[5] = '{1, 1, 2, 3, 3};

    initial begin
        int  cyc, ovf_n, flt_n;
        bit  seen255, wrapped;

        model_reset();
        bus.order = 1'b1;
        bus.cup_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", dut_vec(), 16'h0);
        end
        bus.order = 1'b0;
        rst_n = 1'b1;

        // single order, cup present
        for (int i = 0; i < 14; i++) begin
            tick(i == 0, 1'b1);
            cyc = i + 1;
            if (cyc == 1)  check("pend_c1", 16'(bus.pending), 16'd1);
            if (cyc == 2)  check("drop_c2", 16'(bus.cup_drop), 16'd1);
            if (cyc == 3)  check("wait_c3", 16'({bus.busy, bus.cup_drop, bus.valve_open}), 16'b100);
            if (cyc == 4 || cyc == 11) check("pour_edge", 16'(bus.valve_open), 16'd1);
            if (cyc == 12) check("rinse_c12", 16'({bus.busy, bus.valve_open}), 16'b10);
            if (cyc == 14) check("idle_c14", 16'({bus.busy, bus.served_cnt}), 16'h001);
        end
        async_reset();

        // burst of five orders, queue saturates
        ovf_n = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1);
            check("pend_seq", 16'(bus.pending), 16'(exp_pend[i]));
            if (bus.overflow) ovf_n++;
        end
        check("ovf_c5", 16'(bus.overflow), 16'd1);
        for (int k = 0; k < 200 && (m_phase != PH_IDLE || m_pend != 0); k++) begin
            tick(1'b0, 1'b1);
            if (bus.overflow) ovf_n++;
        end
        check("served_4", 16'(bus.served_cnt), 16'd4);
        check("ovf_count", 16'(ovf_n), 16'd1);
        async_reset();

        // cup never arrives: re-drop after timeout
        flt_n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(i == 0, 1'b0);
            cyc = i + 1;
            if (bus.fault) flt_n++;
            if (cyc == 2 || cyc == 19) check("redrop", 16'(bus.cup_drop), 16'd1);
            if (cyc == 18) check("wait_c18", 16'(bus.cup_drop), 16'd0);
            if (cyc == 19) check("pend_0", 16'(bus.pending), 16'd0);
        end
        check("no_fault", 16'(flt_n), 16'd0);
        async_reset();

        // cup removed in third pour cycle
        for (int i = 0; i < 9; i++) begin
            tick(i == 0, i != 6);
            cyc = i + 1;
            if (cyc == 6) check("pour_c6", 16'(bus.valve_open), 16'd1);
            if (cyc == 7) check("abort_c7", 16'({bus.valve_open, bus.fault, bus.busy}), 16'b011);
            if (cyc == 8) check("rinse_c8", 16'({bus.busy, bus.fault}), 16'b10);
            if (cyc == 9) check("idle_c9", 16'({bus.busy, bus.served_cnt}), 16'h000);
        end
        async_reset();

        // served counter wrap
        seen255 = 0;
        wrapped = 0;
        for (int k = 0; k < 8000 && !wrapped; k++) begin
            tick(1'b1, 1'b1);
            if (!seen255 && m_served == 255) begin
                check("served_255", 16'(bus.served_cnt), 16'd255);
                seen255 = 1;
            end else if (seen255 && m_served == 0) begin
                check("wrap_0", 16'(bus.served_cnt), 16'd0);
                wrapped = 1;
            end
        end
        if (!wrapped) check("wrap_timeout", 16'd0, 16'd1);

        // reset in the middle of a pour
        for (int k = 0; k < 50 && m_phase != PH_POUR; k++) tick(1'b0, 1'b1);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
        check("valve_pre_rst", 16'(bus.valve_open), 16'd1);
        async_reset();

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            tick($urandom_range(0, 4) == 0, $urandom_range(0, 9) != 0);
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coffee_dispense_sched.md
COFFEE_DISPENSE_SCHED -- requirements
Module: coffee_dispense_sched

Interface
REQ-001 Parameter POUR_CYCLES, default 8: cycles valve_open is held per normal pour, legal range 1..255.
REQ-002 Parameter RINSE_CYCLES, default 2: cycles spent in RINSE after every pour, normal or aborted, legal range 1..255.
REQ-003 Parameter CUP_TIMEOUT, default 16: cycles spent in WAIT_CUP without cup_ready before a cup re-drop, legal range 1..255.
REQ-004 Parameter QUEUE_DEPTH, default 3: maximum pending orders, legal range 1..3.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low (0 = in reset).
REQ-007 order  input  1  each cycle sampled high is one coffee order; consecutive high cycles are separate orders.
REQ-008 cup_ready  input  1  cup-present sensor, level.
REQ-009 cup_drop  output  1  high exactly while state is DROP (one-cycle pulse per drop).
REQ-010 valve_open  output  1  high exactly while state is POUR.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 pending  output  2  registered count of queued orders not yet started.
REQ-013 served_cnt  output  8  registered count of completed pours, wraps 255->0.
REQ-014 overflow  output  1  registered one-cycle pulse, cycle after an order is dropped.
REQ-015 fault  output  1  registered one-cycle pulse, cycle after a pour is aborted.

Function
REQ-016 State machine SHALL have states IDLE, DROP, WAIT_CUP, POUR, RINSE; cup_drop, valve_open and busy decoded from state only (Moore).
REQ-017 IDLE -> DROP when pending != 0; otherwise remain IDLE.
REQ-018 DROP -> WAIT_CUP unconditionally after one cycle.
REQ-019 WAIT_CUP -> POUR when cup_ready = 1; else after CUP_TIMEOUT consecutive WAIT_CUP cycles -> DROP (re-drop; pending unchanged, no fault).
REQ-020 POUR lasts POUR_CYCLES cycles, then -> RINSE with served_cnt incremented by 1 on that transition edge.
REQ-021 cup_ready = 0 sampled in any POUR cycle -> RINSE next edge, served_cnt unchanged, fault pulses next cycle.
REQ-022 RINSE lasts RINSE_CYCLES cycles, then -> IDLE.
REQ-023 One shared 8-bit down-timer serves WAIT_CUP, POUR and RINSE, reloaded on every entry to each of those states.
REQ-024 pending increments on each edge with order = 1 and decrements on the IDLE->DROP edge; both on the same edge leaves it unchanged.
REQ-025 pending = QUEUE_DEPTH with order = 1 and no decrement on that edge: order dropped, pending unchanged, overflow pulses next cycle.
REQ-026 pending = QUEUE_DEPTH with order = 1 and simultaneous decrement: order accepted, no overflow.
REQ-027 Orders are accepted in every state, including while busy.
REQ-028 Latency: order sampled on edge n -> pending = 1 after edge n; cup_drop high in the cycle after edge n+1.

Reset
REQ-029 reset = 0 SHALL immediately force state IDLE, timer 0, pending 0, served_cnt 0, and cup_drop, valve_open, busy, overflow and fault to 0, independent of clk.
REQ-030 Reset mid-operation discards the in-progress order and all queued orders; no fault or overflow is produced.
REQ-031 First state change after reset deassertion occurs on the first rising edge with reset = 1.

Verification
REQ-032 reset = 0 for 3 cycles with order = 1 -> all outputs 0, pending 0 throughout.
REQ-033 Single order at cycle 0, cup_ready = 1, defaults -> cup_drop in cycle 2, WAIT_CUP in cycle 3, valve_open in cycles 4-11, RINSE in cycles 12-13, IDLE with busy = 0 at cycle 14, served_cnt = 1.
REQ-034 order high in cycles 0-4, cup_ready = 1 -> pending sequence 1,1,2,3,3; one overflow pulse in cycle 5; 4 pours complete; final served_cnt = 4.
REQ-035 One order, cup_ready held 0 -> cup_drop pulses at cycle 2 and again 17 cycles later; pending stays 0; no fault.
REQ-036 cup_ready dropped in the 3rd valve_open cycle -> valve_open low the next cycle, fault pulse, RINSE for 2 cycles, served_cnt unchanged.
REQ-037 served_cnt = 255 plus one completed pour -> served_cnt = 0; reset asserted mid-POUR -> valve_open 0 without a clock edge.
